// File: rtl/seq_sub.sv
// Multi-cycle two's-complement subtractor: diff = a + ~b + 1, CHUNK bits per clock
// through a registered carry, with Y86 flags (ZF, SF, OF) and unsigned borrow.
module seq_sub #(
   parameter int WIDTH = 64,
   parameter int CHUNK = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             overflow,
   output logic             zf,
   output logic             sf,
   output logic             borrow
);

   localparam int N  = WIDTH / CHUNK;
   localparam int CW = $clog2(N + 1);
   localparam logic [CW-1:0] LAST = CW'(N);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t           state_q;
   logic [WIDTH-1:0] opa_q, opb_q, res_q;
   logic [CHUNK-1:0] sla_q, slb_q;
   logic             carry_q;
   logic [CW-1:0]    cnt_q;
   logic             busy_q, done_q, ovf_q, zf_q, sf_q, borrow_q;
   logic [WIDTH-1:0] diff_q;

   logic [CHUNK:0]   sum_d;
   logic [CHUNK-1:0] low_d;
   logic             cmsb_d;
   logic [CW-1:0]    idx_d;
   logic [WIDTH-1:0] res_d;

   // Slice operands are registered one cycle ahead of the add so the slice mux
   // stays off the carry path; the add therefore trails the fetch by one count.
   always_comb begin
      sum_d  = {1'b0, sla_q} + {1'b0, slb_q} + {{CHUNK{1'b0}}, carry_q};
      low_d  = {1'b0, sla_q[CHUNK-2:0]} + {1'b0, slb_q[CHUNK-2:0]}
             + {{(CHUNK-1){1'b0}}, carry_q};
      cmsb_d = low_d[CHUNK-1];
      idx_d  = cnt_q - 1'b1;
      res_d  = res_q;
      if (cnt_q != '0)
         res_d[idx_d*CHUNK +: CHUNK] = sum_d[CHUNK-1:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         opa_q    <= '0;
         opb_q    <= '0;
         res_q    <= '0;
         sla_q    <= '0;
         slb_q    <= '0;
         carry_q  <= 1'b0;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         diff_q   <= '0;
         ovf_q    <= 1'b0;
         zf_q     <= 1'b0;
         sf_q     <= 1'b0;
         borrow_q <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE, S_DONE: begin
               done_q <= 1'b0;
               if (start) begin
                  opa_q   <= a;
                  opb_q   <= ~b;
                  carry_q <= 1'b1;
                  cnt_q   <= '0;
                  state_q <= S_RUN;
               end else begin
                  state_q <= S_IDLE;
               end
            end
            S_RUN: begin
               if (cnt_q != LAST) begin
                  sla_q <= opa_q[cnt_q*CHUNK +: CHUNK];
                  slb_q <= opb_q[cnt_q*CHUNK +: CHUNK];
               end
               if (cnt_q != '0) begin
                  res_q   <= res_d;
                  carry_q <= sum_d[CHUNK];
               end
               cnt_q <= cnt_q + 1'b1;
               // Final count adds the top slice; flags come from the full result.
               if (cnt_q == LAST) begin
                  state_q  <= S_DONE;
                  busy_q   <= 1'b0;
                  done_q   <= 1'b1;
                  diff_q   <= res_d;
                  ovf_q    <= cmsb_d ^ sum_d[CHUNK];
                  zf_q     <= (res_d == '0);
                  sf_q     <= res_d[WIDTH-1];
                  borrow_q <= ~sum_d[CHUNK];
               end else begin
                  busy_q <= 1'b1;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign diff     = diff_q;
   assign overflow = ovf_q;
   assign zf       = zf_q;
   assign sf       = sf_q;
   assign borrow   = borrow_q;

endmodule

// File: tb/tb_seq_sub.sv
// Directed bench for seq_sub: latency, busy window, result/flags, back-to-back,
// start-while-running and mid-operation reset.
module tb_seq_sub;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [63:0] a, b;
   logic        busy, done, overflow, zf, sf, borrow;
   logic [63:0] diff;

   int checks   = 0;
   int failures = 0;

   seq_sub #(.WIDTH(64), .CHUNK(8)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .a        (a),
      .b        (b),
      .busy     (busy),
      .done     (done),
      .diff     (diff),
      .overflow (overflow),
      .zf       (zf),
      .sf       (sf),
      .borrow   (borrow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Accept one operation, optionally pulse start again on RUN cycle 'inject',
   // then wait (bounded) for done and check latency, busy window and results.
   task automatic run_op(input string tag, input logic [63:0] av, input logic [63:0] bv,
                         input logic [63:0] ed, input logic eo, input logic ez,
                         input logic es, input logic eb, input int inject);
      int lat;
      int bcnt;
      a = av;
      b = bv;
      start = 1'b1;
      step();
      start = 1'b0;
      a = 64'hDEAD_BEEF_0BAD_F00D;
      b = 64'h0123_4567_89AB_CDEF;
      lat  = 0;
      bcnt = 0;
      while (lat < 20) begin
         step();
         lat++;
         if (done) break;
         if (busy) bcnt++;
         start = (lat == inject);
         if (lat == inject) begin
            a = 64'd7;
            b = 64'd7;
         end
      end
      start = 1'b0;
      chk({tag, "_latency"}, 64'(lat), 64'd9);
      chk({tag, "_busy_cycles"}, 64'(bcnt), 64'd8);
      chk({tag, "_diff"}, diff, ed);
      chk({tag, "_overflow"}, {63'd0, overflow}, {63'd0, eo});
      chk({tag, "_zf"}, {63'd0, zf}, {63'd0, ez});
      chk({tag, "_sf"}, {63'd0, sf}, {63'd0, es});
      chk({tag, "_borrow"}, {63'd0, borrow}, {63'd0, eb});
   endtask

   initial begin
      int dcnt;
      rst_n = 1'b0;
      start = 1'b0;
      a = '0;
      b = '0;
      #12;
      chk("rst_busy", {63'd0, busy}, 64'd0);
      chk("rst_done", {63'd0, done}, 64'd0);
      chk("rst_diff", diff, 64'd0);
      chk("rst_flags", {60'd0, overflow, zf, sf, borrow}, 64'd0);
      rst_n = 1'b1;
      step();

      // Basic subtraction, then done must drop in the following idle cycle
      run_op("t1", 64'd5, 64'd3, 64'd2, 1'b0, 1'b0, 1'b0, 1'b0, 0);
      step();
      chk("t1_done_pulse", {63'd0, done}, 64'd0);
      chk("t1_busy_idle", {63'd0, busy}, 64'd0);
      chk("t1_diff_hold", diff, 64'd2);

      run_op("t2", 64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b1, 0);
      step();
      run_op("t3a", 64'h8000_0000_0000_0000, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF,
             1'b1, 1'b0, 1'b0, 1'b0, 0);
      step();
      run_op("t3b", 64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
             64'h8000_0000_0000_0000, 1'b1, 1'b0, 1'b1, 1'b1, 0);
      step();

      // Second start accepted in the done cycle, no idle bubble
      run_op("t4a", 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 64'd0,
             1'b0, 1'b1, 1'b0, 1'b0, 0);
      run_op("t4b", 64'd10, 64'd20, 64'hFFFF_FFFF_FFFF_FFF6, 1'b0, 1'b0, 1'b1, 1'b1, 0);
      step();

      // Start pulsed during RUN must be ignored
      run_op("t5", 64'd100, 64'd1, 64'd99, 1'b0, 1'b0, 1'b0, 1'b0, 3);
      dcnt = 0;
      for (int i = 0; i < 12; i++) begin
         step();
         if (done) dcnt++;
      end
      chk("t5_extra_done", 64'(dcnt), 64'd0);

      // Asynchronous reset in the middle of an operation
      a = 64'h55;
      b = 64'h01;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 4; i++) step();
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6_rst_busy", {63'd0, busy}, 64'd0);
      chk("t6_rst_done", {63'd0, done}, 64'd0);
      chk("t6_rst_diff", diff, 64'd0);
      step();
      step();
      rst_n = 1'b1;
      dcnt = 0;
      for (int i = 0; i < 12; i++) begin
         step();
         if (done) dcnt++;
      end
      chk("t6_no_done", 64'(dcnt), 64'd0);
      run_op("t6", 64'h10, 64'h01, 64'h0F, 1'b0, 1'b0, 1'b0, 1'b0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/seq_sub.md
Name: seq_sub

Overview:
- Multi-cycle 64-bit two's-complement subtractor for the SEQ ALU: computes `diff = a - b` as `a + ~b + 1`.
- Processes CHUNK bits per clock through a registered carry chain and reports Y86 condition flags (ZF, SF, OF) plus borrow.
- Complements the combinational adder. It is used where the execute stage tolerates multi-cycle latency in exchange for a short carry path.
- Start/done handshake toward the execute-stage controller.

Parameters:
- WIDTH, 64, operand/result width in bits.
- CHUNK, 8, bits processed per cycle. Must divide WIDTH; N = WIDTH/CHUNK cycles per operation.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request. Sampled only in IDLE or DONE.
- a  input  WIDTH  minuend. Sampled when start is accepted.
- b  input  WIDTH  subtrahend. Sampled when start is accepted.
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse when result and flags become valid
- diff  output  WIDTH  a - b mod 2^WIDTH. Held until the next accepted start completes.
- overflow  output  1  signed overflow = carry into MSB XOR carry out of MSB
- zf  output  1  diff == 0
- sf  output  1  diff[WIDTH-1]
- borrow  output  1  NOT carry-out of MSB (unsigned a < b)

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE.
  - busy, done, diff, overflow, zf, sf, borrow all 0.
  - Internal operand registers, carry register and chunk counter cleared.
- States: IDLE, RUN, DONE.
- IDLE/DONE with start=1 (accept):
  - Latch a into opA and ~b into opB; carry register = 1; counter = 0.
  - Go to RUN; busy = 1 from the next cycle.
  - diff/flags keep old values until overwritten at completion.
- RUN, each cycle:
  - Add the CHUNK-bit slice `counter*CHUNK +: CHUNK` of opA and opB with the carry register.
  - Write the sum slice into the result register.
  - Update the carry register with the slice carry-out; increment counter.
  - On the final slice (counter == N-1), also capture the carry into bit WIDTH-1 for the overflow computation.
- Completion: after the cycle processing slice N-1, go to DONE.
  - diff, overflow, zf, sf, borrow update in that same edge.
  - done = 1 for exactly that one cycle; busy = 0.
- Latency: start sampled high at edge T gives done high after edge T+N+1, i.e. N+1 cycles. For WIDTH=64, CHUNK=8 that is done 9 cycles after start.
- DONE with start=0: return to IDLE, done = 0. Outputs hold.
- DONE with start=1: accept immediately (back-to-back operations, no idle bubble).
- start while in RUN: ignored. The in-flight operation and its operands are unaffected.
- Arithmetic is modular 2^WIDTH; no saturation.
- zf is computed on the full final diff, not per slice.
- Flags are valid only from done onward. They hold their previous values while busy.
- Reset asserted mid-operation: immediate abort to the reset state; no done pulse. An operation can be restarted in the cycle after rst_n deasserts.
- Operand inputs may change freely after the accept edge.

Test Plan:
1. a=5, b=3, start for 1 cycle -> done exactly 9 cycles later. diff=2, zf=0, sf=0, overflow=0, borrow=0. busy high for the 8 intervening cycles.
2. a=0, b=1 -> diff=0xFFFF_FFFF_FFFF_FFFF, sf=1, borrow=1, overflow=0, zf=0.
3. a=0x8000_0000_0000_0000, b=1 -> diff=0x7FFF_FFFF_FFFF_FFFF, overflow=1, sf=0, borrow=0. Also a=0x7FFF_FFFF_FFFF_FFFF, b=0xFFFF_FFFF_FFFF_FFFF -> diff=0x8000_0000_0000_0000, overflow=1, sf=1, borrow=1.
4. a=b=0x1234_5678_9ABC_DEF0 -> diff=0, zf=1, borrow=0. Then start held high in the done cycle with a=10, b=20 -> second done 9 cycles later with diff=0xFFFF_FFFF_FFFF_FFF6, sf=1, borrow=1.
5. Start a=100, b=1, then pulse start with a=7, b=7 on cycle 3 of RUN -> ignored. Result diff=99 at the expected cycle; only one done pulse.
6. Pull rst_n low on cycle 4 of RUN -> all outputs 0 immediately, no done pulse. After release, a=0x10, b=0x01 -> diff=0x0F after 9 cycles.
